ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch initiator for the pipelined MIPS core. It owns the program counter, drives word addresses onto the instruction-memory read port, and captures the returned instruction word into the IF/ID pipeline register. It honours a stall from hazard logic and a redirect from branch/jump resolution, inserting a no-op bubble on redirect. It sits between the instruction ROM, which is a combinational read with data valid in the same cycle, and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000 — PC value loaded on reset; must be word-aligned.
- `clk  in  1` — rising-edge clock.
- `reset  in  1` — asynchronous, active-high reset.
- `stall  in  1` — hold PC and IF/ID contents this cycle.
- `redirect  in  1` — load `redirect_pc` into PC and flush IF/ID.
- `redirect_pc  in  32` — branch/jump target.
- `imem_addr  out  32` — instruction-memory address; equals the PC register.
- `imem_data  in  32` — instruction word for `imem_addr`, same cycle.
- `ifid_instr  out  32` — registered instruction for decode.
- `ifid_pc4  out  32` — registered PC+4 of `ifid_instr`.
- `ifid_valid  out  1` — `ifid_instr` is a real fetched instruction, not a bubble.
- `misalign_err  out  1` — one-cycle pulse when a misaligned redirect target is taken.

## Operation
- Reset values:
  - PC = `RESET_PC`.
  - `ifid_instr` = 32'h0 (the no-op encoding).
  - `ifid_pc4` = 0.
  - `ifid_valid` = 0.
  - `misalign_err` = 0.
- `imem_addr` is driven directly from the PC register. There is no combinational path from any input to `imem_addr`.
- Next-state priority per rising edge is redirect > stall > sequential.
  - **Redirect** (`redirect` = 1, whatever `stall` is):
    - PC <= {`redirect_pc`[31:2], 2'b00}.
    - `ifid_instr` <= 0, `ifid_pc4` <= 0, `ifid_valid` <= 0.
    - `misalign_err` <= (`redirect_pc`[1:0] != 0).
  - **Stall** (`stall` = 1, `redirect` = 0):
    - PC and all IF/ID outputs hold.
    - `misalign_err` <= 0.
  - **Sequential** (neither asserted):
    - `ifid_instr` <= `imem_data`.
    - `ifid_pc4` <= PC + 4.
    - `ifid_valid` <= 1.
    - PC <= next_pc, where next_pc = PC + 4 unless the early-jump rule under Configuration applies.
- Arithmetic: PC + 4 is a 32-bit unsigned add. It wraps from 32'hFFFF_FFFC to 32'h0 with no flag.
- PC[1:0] is always 00 by construction.

## Timing
- Fetch latency: the instruction at address A appears on `ifid_instr` one cycle after `imem_addr` = A with no stall.
- Throughput: one instruction per cycle while unstalled.
- Redirect penalty:
  - The cycle after `redirect` is sampled, `imem_addr` = target and IF/ID holds a bubble.
  - The target instruction reaches IF/ID one cycle later.
- A stall released in cycle N resumes fetch at the held PC in cycle N. No instruction is lost or duplicated.
- `reset` asserted mid-operation forces every output to its reset value immediately, not at a clock edge.
- The first fetch from `RESET_PC` happens on the first rising edge after `reset` is deasserted.

## Configuration
- Macro: `IFETCH_EARLY_JUMP_EN`.
- **Defined:** on a sequential-advance cycle where `imem_data`[31:26] == 6'd2 (j):
  - next_pc = {(PC+4)[31:28], `imem_data`[25:0], 2'b00}.
  - The jump word itself is still latched into IF/ID with `ifid_valid` = 1, and no bubble is inserted.
  - Redirect and stall still take priority.
- **Undefined:** next_pc is always PC + 4, and jumps are resolved only through `redirect`.

## Structure
- Shared package `ifetch_pkg` holds:
  - `OPC_J` = 6'd2.
  - `NOP_INSTR` = 32'h0.
  - `RESET_PC_DEFAULT`.
  - The 32-bit word typedef.
- One natural sub-module, `ifetch_next_pc`: combinational next-PC selection (redirect / hold / +4 / early jump) with the alignment check. The top level keeps the PC and IF/ID registers.

## Test plan
- **Reset:** hold `reset` high → `imem_addr` = 0x0, `ifid_valid` = 0, `ifid_instr` = 0. After release, `imem_addr` steps 0x0, 0x4, 0x8 on successive edges, and `ifid_instr` follows one cycle later.
- **Stall:** assert `stall` for 3 cycles while PC = 0x8 → `imem_addr` stays 0x8 and IF/ID is frozen. On release, the next IF/ID captures the word at 0x8 with `ifid_pc4` = 0xC.
- **Redirect during stall:** `stall` = 1 and `redirect` = 1 with `redirect_pc` = 0x40 → next cycle `imem_addr` = 0x40, `ifid_valid` = 0, `ifid_instr` = 0. One cycle later `ifid_pc4` = 0x44.
- **Misaligned redirect:** `redirect_pc` = 0x42 → `imem_addr` = 0x40 and `misalign_err` = 1 for exactly one cycle.
- **Early jump:** PC = 0x20 and `imem_data` = 32'h0800_000D →
  - with `IFETCH_EARLY_JUMP_EN`, next `imem_addr` = 0x34 and `ifid_valid` = 1;
  - without it, next `imem_addr` = 0x24.
- **Mid-run reset:** assert `reset` between clock edges during sequential fetch → all outputs reach reset values before the next edge, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Feature macro used by the fetch files: IFETCH_EARLY_JUMP_EN.
package ifetch_pkg;

    typedef logic [31:0] word_t;

    localparam logic [5:0] OPC_J            = 6'd2;
    localparam word_t      NOP_INSTR        = 32'h0000_0000;
    localparam word_t      RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_HOLD,
        PC_REDIR,
        PC_JUMP
    } pc_sel_e;

    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC selection: redirect > stall > early jump > PC+4.
// Early jump decoding exists only when IFETCH_EARLY_JUMP_EN is defined.
module ifetch_next_pc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        misalign_o
);

    pc_sel_e sel;
    word_t   pc_plus4;
    word_t   jump_tgt;
    logic    jump_hit;

    assign pc_plus4 = pc_i + 32'd4;

`ifdef IFETCH_EARLY_JUMP_EN
    assign jump_hit = (imem_data_i[31:26] == OPC_J);
    assign jump_tgt = {pc_plus4[31:28], imem_data_i[25:0], 2'b00};
`else
    logic unused_imem_data;
    assign unused_imem_data = ^imem_data_i;
    assign jump_hit = 1'b0;
    assign jump_tgt = pc_plus4;
`endif

    always_comb begin
        sel = PC_SEQ;
        if (redirect_i) begin
            sel = PC_REDIR;
        end else if (stall_i) begin
            sel = PC_HOLD;
        end else if (jump_hit) begin
            sel = PC_JUMP;
        end
    end

    always_comb begin
        next_pc_o = pc_plus4;
        case (sel)
            PC_REDIR: next_pc_o = word_align(redirect_pc_i);
            PC_HOLD:  next_pc_o = pc_i;
            PC_JUMP:  next_pc_o = jump_tgt;
            default:  next_pc_o = pc_plus4;
        endcase
    end

    assign pc_plus4_o = pc_plus4;
    assign misalign_o = redirect_i && (redirect_pc_i[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: PC register, IMEM address drive and IF/ID register.
// Optional early jump on sequential fetch via IFETCH_EARLY_JUMP_EN.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        misalign_err
);

    word_t pc_q, pc_d;
    word_t instr_q, instr_d;
    word_t pc4_q, pc4_d;
    logic  valid_q, valid_d;
    logic  mis_q, mis_d;
    word_t pc_plus4;

    ifetch_next_pc u_next_pc (
        .pc_i          (pc_q),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_data_i   (imem_data),
        .next_pc_o     (pc_d),
        .pc_plus4_o    (pc_plus4),
        .misalign_o    (mis_d)
    );

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_addr    = pc_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc4     = pc4_q;
    assign ifid_valid   = valid_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table plus scoreboard queue,
// with hand-written reset and mid-run reset sequences.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        misalign_err;
    logic        jump_inject = 1'b0;

    int nchecks = 0;
    int nerrors = 0;

    localparam logic [31:0] JWORD = 32'h0800_000D;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAC00_0000 | {8'h00, a[23:2], 2'b01};
    endfunction

    always_comb begin
        if (jump_inject && imem_addr == 32'h20) imem_data = JWORD;
        else                                    imem_data = mem_word(imem_addr);
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        jmp;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic j, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid, input logic mis);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.jmp = j;
        v.addr = addr; v.instr = instr; v.pc4 = pc4; v.valid = valid; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic check_reset_state(input int idx);
        chk("rst_imem_addr", idx, imem_addr, 32'h0);
        chk("rst_ifid_instr", idx, ifid_instr, 32'h0);
        chk("rst_ifid_pc4", idx, ifid_pc4, 32'h0);
        chk("rst_ifid_valid", idx, {31'b0, ifid_valid}, 32'h0);
        chk("rst_misalign", idx, {31'b0, misalign_err}, 32'h0);
    endtask

    // Called at a negedge: drive, push expectation, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        exp_t e, got_e;
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        jump_inject = v.jmp;
        e.addr = v.addr; e.instr = v.instr; e.pc4 = v.pc4; e.valid = v.valid; e.mis = v.mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", idx);
        end else begin
            got_e = sb.pop_front();
            chk("imem_addr", idx, imem_addr, got_e.addr);
            chk("ifid_instr", idx, ifid_instr, got_e.instr);
            chk("ifid_pc4", idx, ifid_pc4, got_e.pc4);
            chk("ifid_valid", idx, {31'b0, ifid_valid}, {31'b0, got_e.valid});
            chk("misalign_err", idx, {31'b0, misalign_err}, {31'b0, got_e.mis});
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] jaddr1, jaddr2;
`ifdef IFETCH_EARLY_JUMP_EN
        jaddr1 = 32'h34; jaddr2 = 32'h38;
`else
        jaddr1 = 32'h24; jaddr2 = 32'h28;
`endif
        //            stall redir rpc            jmp addr          instr                 pc4           v  mis
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h4,        mem_word(32'h0),      32'h4,        1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h8,        mem_word(32'h4),      32'h8,        1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 32'h8,        mem_word(32'h4),      32'h8,        1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 32'h8,        mem_word(32'h4),      32'h8,        1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 32'h8,        mem_word(32'h4),      32'h8,        1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'hC,        mem_word(32'h8),      32'hC,        1, 0));
        vecs.push_back(mk(1, 1, 32'h40,         0, 32'h40,       32'h0,                32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h44,       mem_word(32'h40),     32'h44,       1, 0));
        vecs.push_back(mk(0, 1, 32'h42,         0, 32'h40,       32'h0,                32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h44,       mem_word(32'h40),     32'h44,       1, 0));
        vecs.push_back(mk(0, 1, 32'h63,         0, 32'h60,       32'h0,                32'h0,        0, 1));
        vecs.push_back(mk(1, 0, 32'h0,          0, 32'h60,       32'h0,                32'h0,        0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC, 32'h0,               32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,        mem_word(32'hFFFF_FFFC), 32'h0,     1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h4,        mem_word(32'h0),      32'h4,        1, 0));
        vecs.push_back(mk(0, 1, 32'h1C,         0, 32'h1C,       32'h0,                32'h0,        0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 32'h20,       mem_word(32'h1C),     32'h20,       1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, jaddr1,       JWORD,                32'h24,       1, 0));
        vecs.push_back(mk(0, 0, 32'h0,          0, jaddr2,       mem_word(jaddr1),     jaddr2,       1, 0));

        // Reset held: outputs at reset values across edges.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state(-1);
        @(posedge clk);
        #1;
        check_reset_state(-2);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i], i);

        // Mid-run reset between edges, then restart from RESET_PC.
        step(mk(0, 0, 32'h0, 0, jaddr2 + 32'd4, mem_word(jaddr2), jaddr2 + 32'd4, 1, 0), 100);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state(101);
        @(negedge clk);
        reset = 1'b0;
        step(mk(0, 0, 32'h0, 0, 32'h4, mem_word(32'h0), 32'h4, 1, 0), 102);
        step(mk(0, 0, 32'h0, 0, 32'h8, mem_word(32'h4), 32'h8, 1, 0), 103);

        if (sb.size() != 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
